branch_pc_unit: RTL and testbench
=================================

BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001: Parameter UUID, default 0, SHALL be the instance identifier; it has no functional effect.
REQ-002: Parameter NAME, default "", SHALL be the instance label; it has no functional effect.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005: instr_valid  input  1  SHALL flag that instr, reg0 and reg3 carry a valid instruction this cycle.
REQ-006: instr  input  8  SHALL be the instruction byte; [7:6] is the class, [2:0] is the condition code.
REQ-007: reg0  input  8  SHALL be the jump target.
REQ-008: reg3  input  8  SHALL be the tested value, interpreted as two's-complement signed.
REQ-009: halt  input  1  SHALL be the stop request.
REQ-010: instr_ready  output  1  SHALL be high when the block can accept an instruction this cycle.
REQ-011: pc  output  8  SHALL be the registered program counter.
REQ-012: flush  output  1  SHALL be a one-cycle pulse marking a taken branch.
REQ-013: taken_count  output  8  SHALL be the registered count of taken branches.
REQ-014: halted  output  1  SHALL be high while in state HALTED.

Function
REQ-015: The block SHALL implement states RUN, BRANCH and HALTED.
REQ-016: instr_ready SHALL be 1 in RUN with halt=0, and 0 otherwise; it is decoded combinationally from state and halt.
REQ-017: An instruction SHALL be accepted only in a cycle where instr_valid=1 and instr_ready=1.
REQ-018: An accepted instruction with instr[7:6]!=2'b11 SHALL update pc to pc+1 mod 256 on that edge; state stays RUN.
REQ-019: An accepted instruction with instr[7:6]==2'b11 SHALL, on that edge, register code=instr[2:0], value=reg3 and target=reg0, and move to BRANCH; pc is unchanged.
REQ-020: In BRANCH the block SHALL evaluate the registered code against the registered value as: 0 never; 1 ==0; 2 <0; 3 <=0; 4 always; 5 !=0; 6 >=0; 7 >0.
REQ-021: On the edge leaving BRANCH, a true condition SHALL set pc to the registered target.
REQ-022: On that same edge, a true condition SHALL assert flush=1 for exactly the following cycle.
REQ-023: On that same edge, a true condition SHALL increment taken_count, saturating at 255.
REQ-024: On the edge leaving BRANCH, a false condition SHALL set pc to pc+1 mod 256, with flush=0 and taken_count unchanged.
REQ-025: BRANCH SHALL last exactly one cycle; branch latency is two cycles from acceptance to the pc update.
REQ-026: Instructions presented during BRANCH SHALL be ignored, since instr_ready=0.
REQ-027: A branch whose target equals the current pc SHALL still count as taken and pulse flush.
REQ-028: pc=255 with a sequential advance SHALL wrap to 0.
REQ-029: halt=1 in RUN SHALL take priority over instr_valid: no instruction is accepted, pc is held, and the next state is HALTED.
REQ-030: halt=1 during BRANCH SHALL let the branch complete its pc, flush and count update on that edge, with next state HALTED.
REQ-031: HALTED SHALL be sticky until rst; pc and taken_count are frozen and flush=0.
REQ-032: instr[5:3] SHALL be ignored.

Reset
REQ-033: rst=1 SHALL force on the next edge: pc=0, state=RUN, flush=0, taken_count=0 and halted=0; any pending branch is discarded.
REQ-034: rst SHALL take priority over every other input, including halt and instr_valid.
REQ-035: The first instruction SHALL be accepted in the first cycle with rst=0.

Verification
REQ-036: Reset, then 3 accepted instr=8'h00 -> pc=3, flush never 1, taken_count=0.
REQ-037: At pc=5, instr=8'hC1 with reg3=0, reg0=8'h40 -> instr_ready=0 for one cycle, then pc=8'h40, a one-cycle flush and taken_count=1; repeating with reg3=1 -> pc=6, no flush.
REQ-038: Sweep codes 0-7 with reg3 in {8'h80, 8'hFF, 0, 1, 8'h7F} -> taken/not-taken matches the REQ-020 table for all 40 cases.
REQ-039: pc=255 with instr=8'h00 -> pc=0; 256 taken branches of code 4 -> taken_count saturates at 255.
REQ-040: halt=1 in the same cycle as a valid instruction -> pc is unchanged and halted=1 next cycle; halt during BRANCH -> branch completes, then halted; held until rst.
REQ-041: rst asserted during BRANCH -> pc=0 and flush=0 next cycle, and the pending branch has no effect.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Program-counter unit with a two-cycle conditional branch and a sticky halt.
// Branch operands are captured on acceptance and resolved in a dedicated BRANCH cycle.
module branch_pc_unit #(
    parameter int UUID = 0,
    parameter     NAME = ""
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    input  logic [7:0] reg0,
    input  logic [7:0] reg3,
    input  logic       halt,
    output logic       instr_ready,
    output logic [7:0] pc,
    output logic       flush,
    output logic [7:0] taken_count,
    output logic       halted
);

    typedef enum logic [1:0] {StRun, StBranch, StHalted} state_e;

    localparam int unused_uuid     = UUID;
    localparam int unused_name_len = $bits(NAME);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic       flush_q, flush_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] code_q, code_d;
    logic [7:0] value_q, value_d;
    logic [7:0] target_q, target_d;
    logic       val_zero, val_neg, cond_true;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^instr[5:3];

    assign val_zero = (value_q == 8'h00);
    assign val_neg  = value_q[7];

    always_comb begin
        cond_true = 1'b0;
        case (code_q)
            3'd0:    cond_true = 1'b0;
            3'd1:    cond_true = val_zero;
            3'd2:    cond_true = val_neg;
            3'd3:    cond_true = val_neg | val_zero;
            3'd4:    cond_true = 1'b1;
            3'd5:    cond_true = ~val_zero;
            3'd6:    cond_true = ~val_neg;
            default: cond_true = ~val_neg & ~val_zero;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = 1'b0;
        cnt_d       = cnt_q;
        code_d      = code_q;
        value_d     = value_q;
        target_d    = target_q;
        instr_ready = (state_q == StRun) && !halt;
        case (state_q)
            StRun: begin
                // halt outranks a valid instruction in the same cycle
                if (halt) begin
                    state_d = StHalted;
                end else if (instr_valid) begin
                    if (instr[7:6] == 2'b11) begin
                        code_d   = instr[2:0];
                        value_d  = reg3;
                        target_d = reg0;
                        state_d  = StBranch;
                    end else begin
                        pc_d = pc_q + 8'd1;
                    end
                end
            end
            StBranch: begin
                if (cond_true) begin
                    pc_d    = target_q;
                    flush_d = 1'b1;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
                state_d = halt ? StHalted : StRun;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            pc_q     <= 8'h00;
            flush_q  <= 1'b0;
            cnt_q    <= 8'h00;
            code_q   <= 3'd0;
            value_q  <= 8'h00;
            target_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            value_q  <= value_d;
            target_q <= target_d;
        end
    end

    assign pc          = pc_q;
    assign flush       = flush_q;
    assign taken_count = cnt_q;
    assign halted      = (state_q == StHalted);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: a behavioural model queues the expected post-edge
// outputs for every driven cycle; they are popped and compared after the edge.
module tb_branch_pc_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [7:0] instr = 8'h00;
    logic [7:0] reg0 = 8'h00;
    logic [7:0] reg3 = 8'h00;
    logic       halt = 1'b0;
    logic       instr_ready;
    logic [7:0] pc;
    logic       flush;
    logic [7:0] taken_count;
    logic       halted;

    branch_pc_unit #(.UUID(3), .NAME("bpu")) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .reg0        (reg0),
        .reg3        (reg3),
        .halt        (halt),
        .instr_ready (instr_ready),
        .pc          (pc),
        .flush       (flush),
        .taken_count (taken_count),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic       flush;
        logic [7:0] cnt;
        logic       halted;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // model state: 0 run, 1 branch, 2 halted
    int         m_state = 0;
    logic       m_known = 1'b0;
    logic [7:0] m_pc = 8'h00;
    logic [7:0] m_cnt = 8'h00;
    logic [2:0] m_code = 3'd0;
    logic [7:0] m_val = 8'h00;
    logic [7:0] m_tgt = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic cond_model(input logic [2:0] code, input logic [7:0] val);
        int v;
        v = $signed(val);
        case (code)
            3'd0:    return 1'b0;
            3'd1:    return v == 0;
            3'd2:    return v < 0;
            3'd3:    return v <= 0;
            3'd4:    return 1'b1;
            3'd5:    return v != 0;
            3'd6:    return v >= 0;
            default: return v > 0;
        endcase
    endfunction

    task automatic step(input logic v, input logic [7:0] i, input logic [7:0] tgt,
                        input logic [7:0] r3, input logic h, input logic r);
        exp_t e;
        exp_t got;
        logic tk;
        @(negedge clk);
        instr_valid = v;
        instr       = i;
        reg0        = tgt;
        reg3        = r3;
        halt        = h;
        rst         = r;
        #1;
        if (m_known) check("instr_ready", instr_ready, (m_state == 0) && !h);
        e.flush = 1'b0;
        if (r) begin
            m_state = 0;
            m_pc    = 8'h00;
            m_cnt   = 8'h00;
            m_known = 1'b1;
        end else if (m_state == 0) begin
            if (h) m_state = 2;
            else if (v && i[7:6] == 2'b11) begin
                m_code  = i[2:0];
                m_val   = r3;
                m_tgt   = tgt;
                m_state = 1;
            end else if (v) m_pc = m_pc + 8'd1;
        end else if (m_state == 1) begin
            tk = cond_model(m_code, m_val);
            if (tk) begin
                m_pc    = m_tgt;
                e.flush = 1'b1;
                m_cnt   = (m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1;
            end else m_pc = m_pc + 8'd1;
            m_state = h ? 2 : 0;
        end
        e.pc     = m_pc;
        e.cnt    = m_cnt;
        e.halted = (m_state == 2);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            got = sb_q.pop_front();
            check("pc", pc, got.pc);
            check("flush", flush, got.flush);
            check("taken_count", taken_count, got.cnt);
            check("halted", halted, got.halted);
        end
    endtask

    task automatic branch(input logic [2:0] code, input logic [7:0] tgt, input logic [7:0] r3);
        step(1'b1, {2'b11, 3'($urandom_range(0, 7)), code}, tgt, r3, 1'b0, 1'b0);
        // presented during BRANCH and must be ignored
        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    logic [7:0] sweep_vals [5];

    initial begin
        sweep_vals[0] = 8'h80;
        sweep_vals[1] = 8'hFF;
        sweep_vals[2] = 8'h00;
        sweep_vals[3] = 8'h01;
        sweep_vals[4] = 8'h7F;

        // reset with every other input active
        step(1'b1, 8'hC4, 8'h55, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

        // sequential advance, first instruction accepted right after reset
        for (int k = 0; k < 3; k++) step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("pc_after_3", pc, 8'd3);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h3F, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0);

        // pc=5: taken ==0 branch, then not-taken repeat
        branch(3'd1, 8'h40, 8'h00);
        check("pc_taken", pc, 8'h40);
        branch(3'd1, 8'h40, 8'h01);

        for (int c = 0; c < 8; c++)
            for (int s = 0; s < 5; s++)
                branch(3'(c), 8'($urandom_range(0, 255)), sweep_vals[s]);

        // target equal to current pc still counts as taken
        branch(3'd4, pc, 8'h00);

        branch(3'd4, 8'hFF, 8'h00);
        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("pc_wrap", pc, 8'h00);

        for (int k = 0; k < 256; k++) branch(3'd4, 8'($urandom_range(0, 255)), 8'h00);
        check("cnt_sat", taken_count, 8'd255);

        // halt beats a valid instruction, then sticks
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 8'hC4, 8'h20, 8'h00, 1'b0, 1'b0);

        // halt during BRANCH: branch completes, then halted
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hC4, 8'h77, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        check("halt_br_pc", pc, 8'h77);
        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hC4, 8'h12, 8'h00, 1'b1, 1'b0);

        // reset during BRANCH discards the pending branch
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hC4, 8'h99, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("pc_after_rst_br", pc, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
